// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared definitions for the single-cycle RV32I-subset core:
//               opcodes, funct3/funct7 codes, ALU/immediate/writeback selects,
//               the control bundle and the built-in instruction ROM image.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // funct3 codes
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  // funct7 codes
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // addi x0,x0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_SLT   = 3'd4,
    ALU_PASSB = 3'd5
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  typedef struct packed {
    logic     reg_write;
    logic     mem_write;
    logic     alu_src_imm;  // ALU operand B from immediate instead of rs2
    logic     branch;       // conditional branch instruction
    logic     branch_ne;    // invert equality test (bne)
    logic     jump;         // unconditional PC-relative jump (jal)
    wb_sel_t  wb_sel;
    imm_sel_t imm_sel;
    alu_op_t  alu_op;
  } ctrl_t;

  // Control word of an unrecognised instruction: PC+4, nothing written.
  localparam ctrl_t CTRL_NOP = '{
    reg_write:   1'b0,
    mem_write:   1'b0,
    alu_src_imm: 1'b0,
    branch:      1'b0,
    branch_ne:   1'b0,
    jump:        1'b0,
    wb_sel:      WB_ALU,
    imm_sel:     IMM_I,
    alu_op:      ALU_ADD
  };

  // Built-in test program, indexed by word. Unused words read as nop.
  function automatic logic [31:0] rom_word(input logic [31:0] idx);
    logic [31:0] w;
    w = NOP_WORD;
    case (idx)
      32'd0:   w = 32'h0050_0093;  // addi x1,x0,5
      32'd1:   w = 32'h00A0_0113;  // addi x2,x0,10
      32'd2:   w = 32'h0020_81B3;  // add  x3,x1,x2
      32'd3:   w = 32'h4011_0233;  // sub  x4,x2,x1
      32'd4:   w = 32'h0030_2023;  // sw   x3,0(x0)
      32'd5:   w = 32'h0000_2283;  // lw   x5,0(x0)
      32'd6:   w = 32'h0012_0463;  // beq  x4,x1,+8
      32'd7:   w = 32'h0630_0293;  // addi x5,x0,99
      32'd8:   w = 32'h0000_006F;  // jal  x0,0
      default: w = NOP_WORD;
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/parte_operativa.sv
`default_nettype none
// ============================================================================
// Module      : parte_operativa
// Description : Datapath of the single-cycle core: PC, register file,
//               instruction ROM, immediate generator, ALU, branch compare,
//               data RAM and writeback mux.
//   clk        in   clock, all state on rising edge
//   reset      in   synchronous active-high; clears PC and register file
//   i_ctrl     in   decoded control bundle for the current instruction
//   o_opcode   out  opcode field of the fetched instruction
//   o_funct3   out  funct3 field
//   o_funct7   out  funct7 field
// Revision    : 1.0 - initial release
// ============================================================================
module parte_operativa
  import riscv_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  ctrl_t       i_ctrl,
  output logic [6:0]  o_opcode,
  output logic [2:0]  o_funct3,
  output logic [6:0]  o_funct7
);

  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);

  // Architectural state; PC and reg_file names are probed from outside.
  logic [31:0] PC;
  logic [31:0] reg_file [0:31];
  logic [31:0] r_dmem   [0:DMEM_DEPTH-1];

  logic [IW-1:0] w_fetch_idx;
  logic [31:0]   w_instr;
  logic [4:0]    w_rs1;
  logic [4:0]    w_rs2;
  logic [4:0]    w_rd;
  logic [31:0]   w_rs1_val;
  logic [31:0]   w_rs2_val;
  logic [31:0]   w_imm;
  logic [31:0]   w_alu_b;
  logic [31:0]   w_alu_y;
  logic [DW-1:0] w_dmem_idx;
  logic [31:0]   w_dmem_rdata;
  logic [31:0]   w_pc_plus4;
  logic [31:0]   w_pc_target;
  logic          w_take;
  logic [31:0]   w_next_pc;
  logic [31:0]   w_wb_data;

  // Fetch: word index wraps modulo ROM depth.
  assign w_fetch_idx = PC[IW+1:2];
  assign w_instr     = rom_word({{(32-IW){1'b0}}, w_fetch_idx});

  assign o_opcode = w_instr[6:0];
  assign o_funct3 = w_instr[14:12];
  assign o_funct7 = w_instr[31:25];
  assign w_rd     = w_instr[11:7];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];

  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : reg_file[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : reg_file[w_rs2];

  // Immediate generation, sign-extended from instruction bit 31.
  always_comb begin
    w_imm = 32'd0;
    case (i_ctrl.imm_sel)
      IMM_I:   w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
      IMM_S:   w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
      IMM_B:   w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                        w_instr[30:25], w_instr[11:8], 1'b0};
      IMM_J:   w_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                        w_instr[20], w_instr[30:21], 1'b0};
      IMM_U:   w_imm = {w_instr[31:12], 12'd0};
      default: w_imm = 32'd0;
    endcase
  end

  assign w_alu_b = i_ctrl.alu_src_imm ? w_imm : w_rs2_val;

  always_comb begin
    w_alu_y = 32'd0;
    case (i_ctrl.alu_op)
      ALU_ADD:   w_alu_y = w_rs1_val + w_alu_b;
      ALU_SUB:   w_alu_y = w_rs1_val - w_alu_b;
      ALU_AND:   w_alu_y = w_rs1_val & w_alu_b;
      ALU_OR:    w_alu_y = w_rs1_val | w_alu_b;
      ALU_SLT:   w_alu_y = {31'd0, ($signed(w_rs1_val) < $signed(w_alu_b))};
      ALU_PASSB: w_alu_y = w_alu_b;
      default:   w_alu_y = 32'd0;
    endcase
  end

  // Data RAM: combinational read, word-indexed, wraps modulo depth.
  assign w_dmem_idx   = w_alu_y[DW+1:2];
  assign w_dmem_rdata = r_dmem[w_dmem_idx];

  // Next PC: beq/bne share the equality comparator, branch_ne flips it.
  assign w_pc_plus4  = PC + 32'd4;
  assign w_pc_target = PC + w_imm;
  assign w_take      = i_ctrl.jump |
                       (i_ctrl.branch & ((w_rs1_val == w_rs2_val) ^ i_ctrl.branch_ne));
  assign w_next_pc   = w_take ? w_pc_target : w_pc_plus4;

  always_comb begin
    w_wb_data = w_alu_y;
    case (i_ctrl.wb_sel)
      WB_ALU:  w_wb_data = w_alu_y;
      WB_MEM:  w_wb_data = w_dmem_rdata;
      WB_PC4:  w_wb_data = w_pc_plus4;
      default: w_wb_data = w_alu_y;
    endcase
  end

  // Reset wins over the instruction in flight: nothing retires on that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      PC <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        reg_file[i] <= 32'd0;
      end
    end else begin
      PC <= w_next_pc;
      if (i_ctrl.reg_write && (w_rd != 5'd0)) begin
        reg_file[w_rd] <= w_wb_data;
      end
    end
  end

  // RAM contents survive reset; only the store is suppressed.
  always_ff @(posedge clk) begin
    if (!reset && i_ctrl.mem_write) begin
      r_dmem[w_dmem_idx] <= w_rs2_val;
    end
  end

endmodule
`default_nettype wire

// File: rtl/riscv_monociclo_top.sv
`default_nettype none
// ============================================================================
// Module      : riscv_monociclo_top
// Description : Single-cycle RV32I-subset processor. Main control decoder
//               plus the datapath (u_parte_operativa) holding ROM and RAM.
//   clk    in  clock, every rising edge retires one instruction
//   reset  in  synchronous active-high reset
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_monociclo_top
  import riscv_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input  logic clk,
  input  logic reset
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  ctrl_t      w_ctrl;

  // Main decoder: anything not explicitly recognised stays CTRL_NOP.
  always_comb begin
    w_ctrl = CTRL_NOP;
    case (w_opcode)
      OP_R: begin
        if (w_funct7 == F7_BASE) begin
          case (w_funct3)
            F3_ADD_SUB: begin w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = ALU_ADD; end
            F3_SLT:     begin w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = ALU_SLT; end
            F3_OR:      begin w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = ALU_OR;  end
            F3_AND:     begin w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = ALU_AND; end
            default:    w_ctrl = CTRL_NOP;
          endcase
        end else if ((w_funct7 == F7_SUB) && (w_funct3 == F3_ADD_SUB)) begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.alu_op    = ALU_SUB;
        end
      end
      OP_I: begin
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.imm_sel     = IMM_I;
        case (w_funct3)
          F3_ADD_SUB: begin w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = ALU_ADD; end
          F3_SLT:     begin w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = ALU_SLT; end
          F3_OR:      begin w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = ALU_OR;  end
          F3_AND:     begin w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = ALU_AND; end
          default:    w_ctrl = CTRL_NOP;
        endcase
      end
      OP_LOAD: begin
        if (w_funct3 == F3_LW) begin
          w_ctrl.reg_write   = 1'b1;
          w_ctrl.alu_src_imm = 1'b1;
          w_ctrl.imm_sel     = IMM_I;
          w_ctrl.alu_op      = ALU_ADD;
          w_ctrl.wb_sel      = WB_MEM;
        end
      end
      OP_STORE: begin
        if (w_funct3 == F3_SW) begin
          w_ctrl.mem_write   = 1'b1;
          w_ctrl.alu_src_imm = 1'b1;
          w_ctrl.imm_sel     = IMM_S;
          w_ctrl.alu_op      = ALU_ADD;
        end
      end
      OP_BRANCH: begin
        if ((w_funct3 == F3_BEQ) || (w_funct3 == F3_BNE)) begin
          w_ctrl.branch    = 1'b1;
          w_ctrl.branch_ne = (w_funct3 == F3_BNE);
          w_ctrl.imm_sel   = IMM_B;
        end
      end
      OP_JAL: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.jump      = 1'b1;
        w_ctrl.imm_sel   = IMM_J;
        w_ctrl.wb_sel    = WB_PC4;
      end
      OP_LUI: begin
        w_ctrl.reg_write   = 1'b1;
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.imm_sel     = IMM_U;
        w_ctrl.alu_op      = ALU_PASSB;
      end
      default: w_ctrl = CTRL_NOP;
    endcase
  end

  parte_operativa #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .DMEM_DEPTH (DMEM_DEPTH)
  ) u_parte_operativa (
    .clk      (clk),
    .reset    (reset),
    .i_ctrl   (w_ctrl),
    .o_opcode (w_opcode),
    .o_funct3 (w_funct3),
    .o_funct7 (w_funct7)
  );

endmodule
`default_nettype wire

// File: tb/tb_riscv_monociclo_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_monociclo_top
// Description : Directed bench for riscv_monociclo_top; walks the built-in
//               program and compares PC, registers and RAM word 0 against
//               hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_monociclo_top;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  riscv_monociclo_top #(
    .IMEM_DEPTH (64),
    .DMEM_DEPTH (64)
  ) dut (
    .clk   (clk),
    .reset (reset)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " PC"}, dut.u_parte_operativa.PC, 32'h0);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("%s x%0d", tag, i), dut.u_parte_operativa.reg_file[i], 32'h0);
    end
  endtask

  task automatic check_final(input string tag);
    check({tag, " PC"}, dut.u_parte_operativa.PC, 32'h20);
    check({tag, " x0"}, dut.u_parte_operativa.reg_file[0], 32'd0);
    check({tag, " x1"}, dut.u_parte_operativa.reg_file[1], 32'd5);
    check({tag, " x2"}, dut.u_parte_operativa.reg_file[2], 32'd10);
    check({tag, " x3"}, dut.u_parte_operativa.reg_file[3], 32'd15);
    check({tag, " x4"}, dut.u_parte_operativa.reg_file[4], 32'd5);
    check({tag, " x5"}, dut.u_parte_operativa.reg_file[5], 32'd15);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;

    // Reset held for two edges
    step(2);
    check_all_zero("reset");

    // Three instructions: addi, addi, add
    reset = 1'b0;
    step(3);
    check("run3 x1", dut.u_parte_operativa.reg_file[1], 32'd5);
    check("run3 x2", dut.u_parte_operativa.reg_file[2], 32'd10);
    check("run3 x3", dut.u_parte_operativa.reg_file[3], 32'd15);
    check("run3 PC", dut.u_parte_operativa.PC, 32'h0C);

    // sub, sw, lw
    step(3);
    check("run6 x4",     dut.u_parte_operativa.reg_file[4], 32'd5);
    check("run6 ram0",   dut.u_parte_operativa.r_dmem[0],   32'd15);
    check("run6 x5",     dut.u_parte_operativa.reg_file[5], 32'd15);
    check("run6 PC",     dut.u_parte_operativa.PC,          32'h18);

    // beq taken skips 0x1C
    step(1);
    check("beq PC", dut.u_parte_operativa.PC, 32'h20);
    check("beq x5", dut.u_parte_operativa.reg_file[5], 32'd15);

    // jal x0,0 parks the PC
    for (int i = 0; i < 20; i++) begin
      step(1);
      check($sformatf("halt PC c%0d", i), dut.u_parte_operativa.PC, 32'h20);
    end
    check_final("halt");

    // Reset, run partway, then reset mid-program
    reset = 1'b1;
    step(1);
    check_all_zero("rst2");
    reset = 1'b0;
    step(4);
    check("part PC", dut.u_parte_operativa.PC, 32'h10);
    check("part x4", dut.u_parte_operativa.reg_file[4], 32'd5);
    reset = 1'b1;
    step(1);
    check_all_zero("midrst");

    // Program re-executes to the same final state
    reset = 1'b0;
    step(7);
    check_final("rerun");
    step(5);
    check_final("rerun hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
